// File: rtl/regfile_driver.sv
// -----------------------------------------------------------------------------
// regfile_driver
//
// Initiator-side controller for a 32-entry (2**ADDR_W) register file. After
// reset it sweeps every register to CLEAR_VALUE, then serves buffered write
// requests and pipelined dual-read requests through valid/ready handshakes.
// A read is only accepted while the write buffer is empty, so every read sees
// all earlier writes. A write accepted on the same edge as a read is ordered
// after it and commits one edge later.
//
// Optional feature macro: REGFILE_DRIVER_ZERO_GUARD_EN
//   When defined, register 0 behaves as a hard-wired zero: writes to it are
//   consumed without asserting reg_write, the sweep writes it with 0, and
//   reads of it return 0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wr_valid/wr_ready        write request handshake (wr_addr, wr_data)
//   rd_valid/rd_ready        dual-read request handshake (rd_addr1, rd_addr2)
//   rd_resp_valid            one-cycle pulse, rd_resp1/rd_resp2 valid
//   clear_done               high once the clear sweep has finished
//   read_reg1/2, write_reg,
//   write_data, reg_write    register-file port bundle (outputs)
//   read_data1/2             register-file combinational read data (inputs)
// -----------------------------------------------------------------------------
module regfile_driver #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 5,
  parameter int                FIFO_DEPTH  = 4,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp1,
  output logic [DATA_W-1:0] rd_resp2,
  output logic              clear_done,
  output logic [ADDR_W-1:0] read_reg1,
  output logic [ADDR_W-1:0] read_reg2,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_sweep_cnt;
  logic                r_clear_done;

  logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [PTR_W:0]      r_count;

  logic [ADDR_W-1:0]   r_read_reg1;
  logic [ADDR_W-1:0]   r_read_reg2;
  logic                r_rd_pend;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp1;
  logic [DATA_W-1:0]   r_resp2;

  logic                w_fifo_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_rd_accept;
  logic                w_wr_ready;
  logic                w_rd_ready;
  logic                w_reg_write;
  logic                w_head_we;
  logic [ADDR_W-1:0]   w_write_reg;
  logic [DATA_W-1:0]   w_write_data;
  logic [DATA_W-1:0]   w_clear_data;
  logic [DATA_W-1:0]   w_rd_data1;
  logic [DATA_W-1:0]   w_rd_data2;

`ifdef REGFILE_DRIVER_ZERO_GUARD_EN
  assign w_clear_data = (r_sweep_cnt == '0) ? '0 : CLEAR_VALUE;
  assign w_head_we    = (r_fifo_addr[r_rptr] != '0);
  assign w_rd_data1   = (r_read_reg1 == '0) ? '0 : read_data1;
  assign w_rd_data2   = (r_read_reg2 == '0) ? '0 : read_data2;
`else
  assign w_clear_data = CLEAR_VALUE;
  assign w_head_we    = 1'b1;
  assign w_rd_data1   = read_data1;
  assign w_rd_data2   = read_data2;
`endif

  assign w_fifo_empty = (r_count == '0);
  // Head entry is consumed even when the zero guard suppresses the write.
  assign w_pop        = (r_state == S_RUN) && !w_fifo_empty;
  assign w_push       = wr_valid && w_wr_ready;
  assign w_rd_accept  = rd_valid && w_rd_ready;

  // Next-state and register-file port decode.
  always_comb begin
    w_state_next = r_state;
    w_wr_ready   = 1'b0;
    w_rd_ready   = 1'b0;
    w_reg_write  = 1'b0;
    w_write_reg  = r_sweep_cnt;
    w_write_data = w_clear_data;
    case (r_state)
      S_CLEAR: begin
        w_reg_write = 1'b1;
        if (r_sweep_cnt == LAST_ADDR) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        // Readiness uses the registered count only; a same-cycle pop
        // does not free a slot.
        w_wr_ready   = (r_count < FULL_CNT);
        w_rd_ready   = w_fifo_empty;
        w_write_reg  = r_fifo_addr[r_rptr];
        w_write_data = r_fifo_data[r_rptr];
        w_reg_write  = !w_fifo_empty && w_head_we;
      end
      default: w_state_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sweep_cnt  <= '0;
      r_clear_done <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      r_sweep_cnt <= r_sweep_cnt + 1'b1;
      if (r_sweep_cnt == LAST_ADDR) begin
        r_clear_done <= 1'b1;
      end
    end
  end

  // Write buffer storage: one enable per entry, no reset needed since the
  // count gates which entries are meaningful.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
    always_ff @(posedge clk) begin
      if (w_push && (r_wptr == gi[PTR_W-1:0])) begin
        r_fifo_addr[gi] <= wr_addr;
        r_fifo_data[gi] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read pipeline: addresses registered on acceptance, data captured one
  // edge later. Capturing before the same-edge write commits is what gives
  // a simultaneous read the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_reg1  <= '0;
      r_read_reg2  <= '0;
      r_rd_pend    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp1      <= '0;
      r_resp2      <= '0;
    end else begin
      r_rd_pend    <= w_rd_accept;
      r_resp_valid <= r_rd_pend;
      if (w_rd_accept) begin
        r_read_reg1 <= rd_addr1;
        r_read_reg2 <= rd_addr2;
      end
      if (r_rd_pend) begin
        r_resp1 <= w_rd_data1;
        r_resp2 <= w_rd_data2;
      end
    end
  end

  assign wr_ready      = w_wr_ready;
  assign rd_ready      = w_rd_ready;
  assign rd_resp_valid = r_resp_valid;
  assign rd_resp1      = r_resp1;
  assign rd_resp2      = r_resp2;
  assign clear_done    = r_clear_done;
  assign read_reg1     = r_read_reg1;
  assign read_reg2     = r_read_reg2;
  assign write_reg     = w_write_reg;
  assign write_data    = w_write_data;
  assign reg_write     = w_reg_write && !rst;

endmodule

// File: tb/tb_regfile_driver.sv
// -----------------------------------------------------------------------------
// tb_regfile_driver
//
// Drives regfile_driver against a simple register-file array and checks it
// every cycle against a transaction-level model: an architectural register
// array, a queue of pending writes and a queue of expected read responses.
// Directed scenarios pin the model with literal values; a randomized phase
// (with one reset in the middle) follows.
// -----------------------------------------------------------------------------
module tb_regfile_driver;

  localparam int          DW    = 32;
  localparam int          AW    = 5;
  localparam int          DEPTH = 4;
  localparam int          NREG  = 32;
  localparam logic [31:0] CV    = 32'h0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr1, rd_addr2;
  logic [DW-1:0] wr_data;
  logic          rd_resp_valid, clear_done, reg_write;
  logic [DW-1:0] rd_resp1, rd_resp2, write_data, read_data1, read_data2;
  logic [AW-1:0] read_reg1, read_reg2, write_reg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_driver #(
    .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .CLEAR_VALUE(CV)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_resp_valid(rd_resp_valid), .rd_resp1(rd_resp1), .rd_resp2(rd_resp2),
    .clear_done(clear_done),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  // Register file seen by the DUT.
  logic [DW-1:0] rf [NREG];
  assign read_data1 = rf[read_reg1];
  assign read_data2 = rf[read_reg2];
  always @(posedge clk) begin
    if (reg_write) rf[write_reg] <= write_data;
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wreq_t;
  typedef struct { int due; logic [DW-1:0] d1; logic [DW-1:0] d2; } rresp_t;

  wreq_t         wq[$];
  rresp_t        respq[$];
  logic [DW-1:0] arch [NREG];
  int            clr_edges = 0;
  int            cyc = 0;
  bit            m_rd_acc, m_wr_acc;
  wreq_t         m_w;
  rresp_t        m_r;

  function automatic logic [DW-1:0] arch_rd(input logic [AW-1:0] a);
`ifdef REGFILE_DRIVER_ZERO_GUARD_EN
    if (a == '0) return '0;
`endif
    return arch[a];
  endfunction

  function automatic logic exp_we(input logic [AW-1:0] a);
`ifdef REGFILE_DRIVER_ZERO_GUARD_EN
    return (a != '0);
`else
    return (a == a);
`endif
  endfunction

  function automatic logic [DW-1:0] exp_clear_data(input int idx);
`ifdef REGFILE_DRIVER_ZERO_GUARD_EN
    if (idx == 0) return '0;
`endif
    return (idx >= 0) ? CV : CV;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wq.delete();
      respq.delete();
      clr_edges = 0;
      cyc       = 0;
      for (int i = 0; i < NREG; i++) arch[i] = CV;
    end else begin
      cyc++;
      if (clr_edges < NREG) begin
        clr_edges++;
      end else begin
        m_rd_acc = rd_valid && (wq.size() == 0);
        m_wr_acc = wr_valid && (wq.size() < DEPTH);
        if (wq.size() > 0) begin
          m_w = wq.pop_front();
          if (exp_we(m_w.a)) arch[m_w.a] = m_w.d;
        end
        // Read is ordered before a write accepted on the same edge.
        if (m_rd_acc) begin
          m_r.due = cyc + 1;
          m_r.d1  = arch_rd(rd_addr1);
          m_r.d2  = arch_rd(rd_addr2);
          respq.push_back(m_r);
        end
        if (m_wr_acc) begin
          m_w.a = wr_addr;
          m_w.d = wr_data;
          wq.push_back(m_w);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_reg_write", reg_write, 0);
      chk("rst_resp_valid", rd_resp_valid, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_ready", rd_ready, 0);
      chk("rst_clear_done", clear_done, 0);
      chk("rst_resp1", rd_resp1, 0);
      chk("rst_resp2", rd_resp2, 0);
      chk("rst_read_reg1", read_reg1, 0);
      chk("rst_read_reg2", read_reg2, 0);
      chk("rst_write_reg", write_reg, 0);
      chk("rst_write_data", write_data, exp_clear_data(0));
    end else if (clr_edges < NREG) begin
      chk("clr_reg_write", reg_write, 1);
      chk("clr_write_reg", write_reg, clr_edges);
      chk("clr_write_data", write_data, exp_clear_data(clr_edges));
      chk("clr_wr_ready", wr_ready, 0);
      chk("clr_rd_ready", rd_ready, 0);
      chk("clr_clear_done", clear_done, 0);
      chk("clr_resp_valid", rd_resp_valid, 0);
    end else begin
      chk("run_clear_done", clear_done, 1);
      chk("run_wr_ready", wr_ready, wq.size() < DEPTH);
      chk("run_rd_ready", rd_ready, wq.size() == 0);
      if (wq.size() > 0) begin
        chk("wr_reg_write", reg_write, exp_we(wq[0].a));
        if (exp_we(wq[0].a)) begin
          chk("wr_write_reg", write_reg, wq[0].a);
          chk("wr_write_data", write_data, wq[0].d);
        end
      end else begin
        chk("idle_reg_write", reg_write, 0);
      end
      if (respq.size() > 0 && respq[0].due == cyc) begin
        chk("resp_valid", rd_resp_valid, 1);
        chk("resp1", rd_resp1, respq[0].d1);
        chk("resp2", rd_resp2, respq[0].d2);
        $display("[TB] rd resp t=%0t r1=%h r2=%h exp=%h,%h", $time,
                 rd_resp1, rd_resp2, respq[0].d1, respq[0].d2);
        void'(respq.pop_front());
      end else begin
        chk("resp_valid_idle", rd_resp_valid, 0);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc = 1'b0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk); acc = wr_ready;
      @(posedge clk); #2;
    end
    chk("wr_accepted", acc, 1);
    $display("[TB] wr addr=%0d data=%0d", a, d);
  endtask

  task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bit acc = 1'b0;
    rd_valid = 1'b1; rd_addr1 = a1; rd_addr2 = a2;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk); acc = rd_ready;
      @(posedge clk); #2;
    end
    rd_valid = 1'b0;
    chk("rd_accepted", acc, 1);
  endtask

  task automatic wait_resp(input string nm, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    bit got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rd_resp_valid) begin
        got = 1'b1;
        chk({nm, "_r1"}, rd_resp1, e1);
        chk({nm, "_r2"}, rd_resp2, e2);
      end
    end
    chk({nm, "_seen"}, got, 1);
  endtask

  task automatic wait_clear();
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); got = clear_done;
    end
    chk("clear_done_seen", got, 1);
    @(posedge clk); #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] zero_exp;
    wr_valid = 1'b0; rd_valid = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("sweep_first_reg", write_reg, 0);
    chk("sweep_first_we", reg_write, 1);
    wait_clear();

    do_read(5'd0, 5'd31);
    wait_resp("rd_0_31", 32'd0, 32'd0);

    do_write(5'd2, 32'd40);
    do_write(5'd4, 32'd80);
    do_write(5'd8, 32'd160);
    do_write(5'd16, 32'd320);
    wr_valid = 1'b0;
    do_read(5'd16, 5'd8);
    wait_resp("rd_16_8", 32'd320, 32'd160);

    // Simultaneous read and write acceptance.
    @(posedge clk); #2;
    rd_valid = 1'b1; rd_addr1 = 5'd2; rd_addr2 = 5'd4;
    wr_valid = 1'b1; wr_addr = 5'd2; wr_data = 32'd99;
    @(negedge clk);
    chk("same_edge_rd_ready", rd_ready, 1);
    chk("same_edge_wr_ready", wr_ready, 1);
    @(posedge clk); #2;
    rd_valid = 1'b0; wr_valid = 1'b0;
    wait_resp("raw_old", 32'd40, 32'd80);
    do_read(5'd2, 5'd2);
    wait_resp("raw_new", 32'd99, 32'd99);

    // Register 0 behaviour.
    do_write(5'd0, 32'd20);
    wr_valid = 1'b0;
    do_read(5'd0, 5'd31);
`ifdef REGFILE_DRIVER_ZERO_GUARD_EN
    zero_exp = 32'd0;
`else
    zero_exp = 32'd20;
`endif
    wait_resp("rd_zero", zero_exp, 32'd0);

    // Reset with a read in flight and a write queued.
    @(posedge clk); #2;
    rd_valid = 1'b1; rd_addr1 = 5'd5; rd_addr2 = 5'd6;
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'd1234;
    @(posedge clk); #1;
    rd_valid = 1'b0; wr_valid = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_no_commit", reg_write, 0);
    chk("mid_rst_no_resp", rd_resp_valid, 0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_no_resp_after", rd_resp_valid, 0);
    chk("resweep_first_reg", write_reg, 0);
    chk("resweep_first_we", reg_write, 1);
    wait_clear();

    // Randomized phase with one reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #2;
      if (i == 700) rst = 1'b1;
      if (i == 703) rst = 1'b0;
      wr_valid = ($urandom_range(0, 99) < 50);
      rd_valid = ($urandom_range(0, 99) < 40);
      wr_addr  = AW'($urandom_range(0, NREG - 1));
      wr_data  = $urandom;
      rd_addr1 = AW'($urandom_range(0, NREG - 1));
      rd_addr2 = AW'($urandom_range(0, NREG - 1));
    end
    @(posedge clk); #2;
    wr_valid = 1'b0; rd_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
